lfsr_scrambler_par: RTL and testbench

Parametrised, multi-bit-per-cycle additive/self-synchronising LFSR scrambler and descrambler with valid/ready streaming handshake, runtime seed load and per-frame reseed. It is the next-generation datapath scrambler for the 802.11b baseband transmit and receive chains. It sits between the framing logic and the modulator on TX, and between the demodulator and deframer on RX. Default parameters reproduce the 802.11b x^7 + x^4 + 1 scrambler.

---
 rtl/scrambler_pkg.sv | 14 +
 rtl/lfsr_step.sv | 30 +++
 rtl/lfsr_scrambler_par.sv | 106 ++++++++++
 tb/tb_lfsr_scrambler_par.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared constants and types for the parallel LFSR scrambler family.
// Defaults reproduce the 802.11b x^7 + x^4 + 1 scrambler.
package scrambler_pkg;

  localparam int unsigned LFSR_W_80211B    = 7;
  localparam logic [6:0]  TAPS_80211B      = 7'b1001000;
  localparam logic [6:0]  SEED_80211B_LONG = 7'b1101100;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } scr_state_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational DATA_W-bit unroll of the additive/self-synchronising LFSR.
// Bit 0 is processed first; also reused by the BIST pattern generator.
module lfsr_step
  import scrambler_pkg::*;
#(
  parameter int unsigned       LFSR_W = LFSR_W_80211B,
  parameter logic [LFSR_W-1:0] TAPS   = TAPS_80211B,
  parameter int unsigned       DATA_W = 8
) (
  input  logic [LFSR_W-1:0] state_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              descramble_i,
  output logic [LFSR_W-1:0] next_state_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s          = state_i;
    out_data_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      out_data_o[i] = data_i[i] ^ (^(s & TAPS));
      // Scrambler feeds back its own output; descrambler feeds back the line bit.
      s = {s[LFSR_W-2:0], descramble_i ? data_i[i] : out_data_o[i]};
    end
    next_state_o = s;
  end

endmodule

// File: rtl/lfsr_scrambler_par.sv
// Multi-bit-per-cycle LFSR scrambler/descrambler with valid/ready streaming,
// runtime seed load and per-frame auto-reseed.
module lfsr_scrambler_par
  import scrambler_pkg::*;
#(
  parameter int unsigned       LFSR_W      = LFSR_W_80211B,
  parameter logic [LFSR_W-1:0] TAPS        = TAPS_80211B,
  parameter logic [LFSR_W-1:0] SEED        = '0,
  parameter int unsigned       DATA_W      = 8,
  parameter bit                AUTO_RESEED = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              descramble,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] state_out,
  output logic [15:0]       beat_count
);

  logic [LFSR_W-1:0] state_q, state_d, step_state, step_next;
  logic [DATA_W-1:0] out_data_q, out_data_d, step_out;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [15:0]       count_q, count_d;
  scr_state_e        fsm_q, fsm_d;
  logic              accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A seed_load coinciding with a beat seeds that very beat.
  assign step_state = seed_load ? seed_value : state_q;

  lfsr_step #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_step (
    .state_i      (step_state),
    .data_i       (in_data),
    .descramble_i (descramble),
    .next_state_o (step_next),
    .out_data_o   (step_out)
  );

  always_comb begin
    state_d     = step_state;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    count_d     = count_q;
    fsm_d       = fsm_q;
    if (accept) begin
      state_d     = (AUTO_RESEED && in_last) ? SEED : step_next;
      out_data_d  = step_out;
      out_valid_d = 1'b1;
      out_last_d  = in_last;
      if (in_last) begin
        fsm_d   = StIdle;
        count_d = '0;
      end else begin
        fsm_d = StRun;
        if (fsm_q == StIdle) begin
          count_d = 16'd1;
        end else if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SEED;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
      fsm_q       <= StIdle;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
      fsm_q       <= fsm_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign state_out  = state_q;
  assign beat_count = count_q;

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
// Self-checking bench for lfsr_scrambler_par at 802.11b defaults: vector table,
// directed frame/stall/reset sequences and a randomised scoreboarded stream.
module tb_lfsr_scrambler_par;

  localparam logic [6:0] TAPS = 7'b1001000;
  localparam logic [6:0] SEED = 7'b0000000;
  localparam int unsigned NBYTES = 1000;

  logic       clock = 1'b0;
  logic       reset, descramble, seed_load, in_valid, in_last, out_ready;
  logic [6:0] seed_value;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;
  logic [6:0] state_out;
  logic [15:0] beat_count;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: line history as a bit queue, hist[0] = newest bit.
  bit         hist[$];
  logic       m_valid, m_last;
  logic [7:0] m_data;
  logic [15:0] m_cnt;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] orig[NBYTES];
  logic [7:0] scr[NBYTES];

  typedef struct {
    logic       desc;
    logic [6:0] seed;
    logic [7:0] din;
    logic [7:0] dout;
    logic [6:0] st;
  } vec_t;
  vec_t vecs[6];

  lfsr_scrambler_par dut (
    .clock      (clock),
    .reset      (reset),
    .descramble (descramble),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .state_out  (state_out),
    .beat_count (beat_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_load(input logic [6:0] sd);
    hist.delete();
    for (int k = 0; k < 7; k++) hist.push_back(sd[k]);
  endfunction

  function automatic logic [6:0] m_state();
    logic [6:0] r;
    for (int k = 0; k < 7; k++) r[k] = hist[k];
    return r;
  endfunction

  // Each output bit is the input bit XOR the line bits k+1 positions back, k in TAPS.
  function automatic logic [7:0] m_beat(input logic [7:0] d, input logic desc);
    logic [7:0] o;
    bit fb;
    for (int i = 0; i < 8; i++) begin
      fb = 1'b0;
      for (int k = 0; k < 7; k++) if (TAPS[k]) fb ^= hist[k];
      o[i] = d[i] ^ fb;
      hist.push_front(desc ? d[i] : o[i]);
      void'(hist.pop_back());
    end
    return o;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    seed_load = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_load(SEED);
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_cnt   = '0;
  endtask

  // Entered and left at posedge+1; drives one cycle, checks, steps the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic last, input logic desc,
                       input logic rdy, input logic sl, input logic [6:0] sv);
    logic acc;
    in_valid   = v;
    in_data    = d;
    in_last    = last;
    descramble = desc;
    out_ready  = rdy;
    seed_load  = sl;
    seed_value = sv;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_last", 32'(out_last), 32'(m_last));
    end
    chk("in_ready", 32'(in_ready), 32'(!m_valid || rdy));
    chk("state_out", 32'(state_out), 32'(m_state()));
    chk("beat_count", 32'(beat_count), 32'(m_cnt));
    if (out_valid && rdy) got_q.push_back(out_data);
    acc = v && (!m_valid || rdy);
    if (sl) m_load(sv);
    if (acc) begin
      m_data  = m_beat(d, desc);
      m_valid = 1'b1;
      m_last  = last;
      exp_q.push_back(m_data);
      if (last) begin
        m_load(SEED);
        m_cnt = '0;
      end else if (m_cnt != 16'hFFFF) begin
        m_cnt++;
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    seed_load = 1'b0;
  endtask

  initial begin
    vecs[0] = '{desc: 1'b0, seed: 7'h00, din: 8'h01, dout: 8'h91, st: 7'h09};
    vecs[1] = '{desc: 1'b1, seed: 7'h00, din: 8'h91, dout: 8'h01, st: 7'h09};
    vecs[2] = '{desc: 1'b0, seed: 7'h00, din: 8'h00, dout: 8'h00, st: 7'h00};
    vecs[3] = '{desc: 1'b1, seed: 7'h00, din: 8'h00, dout: 8'h00, st: 7'h00};
    vecs[4] = '{desc: 1'b0, seed: 7'h40, din: 8'h00, dout: 8'h91, st: 7'h09};
    vecs[5] = '{desc: 1'b1, seed: 7'h40, din: 8'h00, dout: 8'h01, st: 7'h00};

    in_data = '0; in_last = 1'b0; descramble = 1'b0; out_ready = 1'b1; seed_value = '0;
    do_reset();

    // Reset state
    chk("rst_state_out", 32'(state_out), 32'(SEED));
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table: seed_load in the same cycle as the beat; first entry from a nonzero state
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h5A);
    for (int t = 0; t < 6; t++) begin
      cycle(1'b1, vecs[t].din, 1'b0, vecs[t].desc, 1'b1, 1'b1, vecs[t].seed);
      chk("tbl_out_data", 32'(out_data), 32'(vecs[t].dout));
      chk("tbl_state_out", 32'(state_out), 32'(vecs[t].st));
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);

    // Backpressure: 5 stalled cycles with a beat on offer, 10 beats in and out
    do_reset();
    got_q.delete();
    exp_q.delete();
    cycle(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    repeat (5) begin
      cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_data", 32'(out_data), 32'(exp_q[0]));
      chk("bp_beat_count", 32'(beat_count), 32'd1);
    end
    for (int j = 1; j < 10; j++) cycle(1'b1, 8'hA0 + 8'(j), 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    chk("bp_out_count", 32'(got_q.size()), 32'd10);
    chk("bp_in_count", 32'(exp_q.size()), 32'd10);
    for (int j = 0; j < 10 && j < got_q.size() && j < exp_q.size(); j++)
      chk("bp_order", 32'(got_q[j]), 32'(exp_q[j]));

    // Auto-reseed over a 3-beat frame
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h2A);
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    chk("fr_count1", 32'(beat_count), 32'd1);
    chk("fr_last1", 32'(out_last), 32'd0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    chk("fr_count2", 32'(beat_count), 32'd2);
    chk("fr_last2", 32'(out_last), 32'd0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00);
    chk("fr_count3", 32'(beat_count), 32'd0);
    chk("fr_state3", 32'(state_out), 32'(SEED));
    chk("fr_last3", 32'(out_last), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);

    // Reset while the output beat is stalled
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h33);
    cycle(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
    chk("rs_pending", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_state_out", 32'(state_out), 32'(SEED));
    chk("rs_beat_count", 32'(beat_count), 32'd0);
    m_load(SEED); m_valid = 1'b0; m_cnt = '0;

    // Round trip: scramble NBYTES random bytes, then descramble the line stream
    got_q.delete();
    for (int n = 0; n < NBYTES; n++) orig[n] = 8'($urandom);
    for (int n = 0; n < NBYTES; n++)
      cycle(1'b1, orig[n], n == NBYTES - 1, 1'b0, 1'b1, 1'b0, 7'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    chk("rt_scr_count", 32'(got_q.size()), 32'(NBYTES));
    for (int n = 0; n < NBYTES; n++) scr[n] = (n < got_q.size()) ? got_q[n] : 8'h00;
    got_q.delete();
    for (int n = 0; n < NBYTES; n++)
      cycle(1'b1, scr[n], n == NBYTES - 1, 1'b1, 1'b1, 1'b0, 7'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    chk("rt_dsc_count", 32'(got_q.size()), 32'(NBYTES));
    for (int n = 0; n < NBYTES && n < got_q.size(); n++)
      chk("rt_roundtrip", 32'(got_q[n]), 32'(orig[n]));

    // Descrambler joins 3 beats late; it resynchronises within 7 line bits
    got_q.delete();
    for (int n = 3; n < 40; n++)
      cycle(1'b1, scr[n], n == 39, 1'b1, 1'b1, 1'b0, 7'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    chk("ms_count", 32'(got_q.size()), 32'd37);
    for (int n = 1; n < got_q.size(); n++)
      chk("ms_resync", 32'(got_q[n]), 32'(orig[n + 3]));

    // Randomised traffic with backpressure, mode changes, frames and seed loads
    for (int c = 0; c < 600; c++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 7) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, 7'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
